// File: rtl/bitwise_pkg.sv
// Op codes and per-bit evaluation shared by the bitwise unit.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package bitwise_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // One result bit from one bit of each operand; the datapath replicates it per bit.
  function automatic logic bit_op(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    r = a;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic DEPTH-entry FIFO holding DATA_W-bit results; storage cleared on reset.
// Latency: a write is visible at the read port one cycle later.
// Backpressure: wr_rdy = not full (independent of rd_rdy); reads ignored when empty.
module result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign wr_rdy = (count != CNT_W'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow gives the wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Pipelined bitwise unit (8 ops) feeding a result FIFO; zr/ng flags with BITWISE_UNIT_PIPE_OUT_FLAGS_EN.
// Latency: 1 cycle from operand accept to out_data; no combinational in-to-out path.
// Backpressure: in_ready drops only when the FIFO is full; no pass-through on pop.
module bitwise_unit_pipe
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BITWISE_UNIT_PIPE_OUT_FLAGS_EN
  ,
  output logic             out_zr,
  output logic             out_ng
`endif
);

  logic [WIDTH-1:0] res;

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = bit_op(in_op, in_a[i], in_b[i]);
    end
  end

`ifdef BITWISE_UNIT_PIPE_OUT_FLAGS_EN
  localparam int DATA_W = WIDTH + 2;
`else
  localparam int DATA_W = WIDTH;
`endif

  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] rd_dat;

  // Flags are computed at push time so the head entry carries them ready-made.
`ifdef BITWISE_UNIT_PIPE_OUT_FLAGS_EN
  assign wr_dat   = {(res == '0), res[WIDTH-1], res};
  assign out_data = rd_dat[WIDTH-1:0];
  assign out_ng   = rd_dat[WIDTH];
  assign out_zr   = rd_dat[WIDTH+1];
`else
  assign wr_dat   = res;
  assign out_data = rd_dat;
`endif

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (wr_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat)
  );

endmodule
